// File: rtl/irq_controller.sv
// External interrupt controller: synchronised edge/level capture, pending/enable
// registers and a small register window. Optional SWSET register via IRQC_SW_TRIGGER_EN.
module irq_controller #(
  parameter int unsigned NUM_SRC     = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_SRC-1:0]  irq_in,
  input  logic                wr_en,
  input  logic [2:0]          addr,
  input  logic [31:0]         wr_data,
  output logic [31:0]         rd_data,
  output logic [NUM_SRC-1:0]  interrupt_source,
  output logic                irq_any
);

  logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
  logic [NUM_SRC-1:0] s, prev_q, pend_q, enable_q, mode_q;
  logic [NUM_SRC-1:0] pending, w1c, edge_set, pend_nxt, enable_nxt, mode_nxt;
  logic [4:0]         id;
  logic               unused_wr_data;
`ifdef IRQC_SW_TRIGGER_EN
  logic [NUM_SRC-1:0] sw_set;
`endif

  assign unused_wr_data = ^wr_data[31:NUM_SRC];
  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    w1c        = (wr_en && addr == 3'd0) ? wr_data[NUM_SRC-1:0] : '0;
    enable_nxt = (wr_en && addr == 3'd1) ? wr_data[NUM_SRC-1:0] : enable_q;
    mode_nxt   = (wr_en && addr == 3'd2) ? wr_data[NUM_SRC-1:0] : mode_q;
    edge_set   = s & ~prev_q & mode_q;
`ifdef IRQC_SW_TRIGGER_EN
    sw_set     = (wr_en && addr == 3'd4) ? wr_data[NUM_SRC-1:0] : '0;
    // Edge->level switch drops the latch; software set and edge set both beat W1C.
    pend_nxt   = (((pend_q & ~w1c) | edge_set) & ~(mode_q & ~mode_nxt)) | sw_set;
`else
    // Masking with the next MODE keeps the latch clear for level-mode sources.
    pend_nxt   = ((pend_q & ~w1c) | edge_set) & mode_nxt;
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      prev_q   <= '0;
      pend_q   <= '0;
      enable_q <= '0;
      mode_q   <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      prev_q   <= s;
      pend_q   <= pend_nxt;
      enable_q <= enable_nxt;
      mode_q   <= mode_nxt;
    end
  end

  assign pending          = pend_q | (s & ~mode_q);
  assign interrupt_source = pending & enable_q;
  assign irq_any          = |interrupt_source;

  always_comb begin
    id = '0;
    for (int unsigned k = NUM_SRC; k > 0; k--) begin
      if (interrupt_source[k-1]) id = 5'(k-1);
    end
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      3'd0:    rd_data[NUM_SRC-1:0] = pending;
      3'd1:    rd_data[NUM_SRC-1:0] = enable_q;
      3'd2:    rd_data[NUM_SRC-1:0] = mode_q;
      3'd3:    rd_data = irq_any ? {1'b1, 26'b0, id} : '0;
      default: rd_data = '0;
    endcase
  end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- External interrupt controller in front of the CP0 exception unit.
- Synchronises raw device interrupt lines and detects edge- or level-mode events, then latches pending bits and applies per-source enables.
- Drives the 8-bit interrupt_source vector that CP0 samples into Cause[15:8].
- Software configures it, reads it and acknowledges interrupts through a small memory-mapped register window. The handler reads ID, services the source, then write-1-clears PENDING before ERET.

Parameters:
- NUM_SRC, 8, number of interrupt sources. Fixed at 8 to match the Cause IP field; other values are unsupported.
- SYNC_STAGES, 2, depth of the input synchroniser flop chain per source. Must be ≥1.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset (reset==0 resets).
- irq_in  input  8  raw asynchronous device interrupt lines, active-high.
- wr_en  input  1  register write strobe, single cycle.
- addr  input  3  register select for read and write.
- wr_data  input  32  write data; only [7:0] used.
- rd_data  output  32  combinational read data for addr; upper 24 bits zero except ID.
- interrupt_source  output  8  pending & enable, to CP0.
- irq_any  output  1  |interrupt_source.

Behaviour:
- Register map (addr):
  - 0 PENDING: read; write-1-to-clear.
  - 1 ENABLE: read/write; reset 0x00.
  - 2 MODE: read/write; 1=edge, 0=level; reset 0x00.
  - 3 ID: read-only, {valid[31], 26'b0, id[4:0]}. id = lowest-numbered set bit of interrupt_source (bit 0 highest priority); valid=irq_any. When no bit is set, the whole register reads 0.
  - 4 SWSET: see Optional Feature.
  - 5-7: read 0, writes ignored.
- Synchroniser:
  - Per bit, SYNC_STAGES flops; s = last stage.
  - A prev flop holds s delayed one cycle.
- Edge mode (MODE[i]=1):
  - pend_q[i] sets on the clock edge where s[i] & ~prev[i].
  - It stays set until software writes PENDING with bit i=1.
  - Latency: irq_in[i] held high before posedge 1 → pend_q[i]=1 after posedge SYNC_STAGES+1.
- Level mode (MODE[i]=0):
  - PENDING[i] = s[i] directly, no latch; pend_q[i] is held 0.
  - W1C has no effect.
  - Latency: visible after posedge SYNC_STAGES; clears SYNC_STAGES cycles after the device deasserts.
- interrupt_source = PENDING & ENABLE, driven from flops/comb of registered state only. No path from irq_in to the output without passing the synchroniser.
- Disabled sources still latch PENDING. Setting ENABLE later raises interrupt_source in the next cycle.
- Simultaneous events:
  - Edge detect and W1C on the same bit in the same cycle → set wins (pending stays 1).
  - Writes to MODE changing bit i to level clear pend_q[i] in that cycle.
  - Changing bit i to edge does not create a spurious edge: prev keeps tracking s in all modes.
- Writes take effect on the rising edge with wr_en=1; rd_data reflects the new value from the next cycle.
- Reset (asynchronous, mid-operation included):
  - Sync chain, prev, pend_q, ENABLE and MODE all cleared.
  - interrupt_source=0, irq_any=0, rd_data for ID=0.
  - A line already high at release is seen as a rising edge after SYNC_STAGES+1 cycles if MODE is set to edge before then.

Optional Feature:
- Macro IRQC_SW_TRIGGER_EN.
- Defined:
  - addr 4 SWSET is write-only (reads 0).
  - Writing bit i=1 sets pend_q[i] on that edge regardless of MODE. In level mode PENDING[i] = s[i] | pend_q[i], and W1C clears pend_q[i].
  - SWSET and W1C on the same bit in the same cycle → set wins.
- Not defined:
  - addr 4 behaves like 5-7.
  - pend_q is never set in level mode.

Test Plan:
- Reset then ENABLE=0x00, MODE=0x00, irq_in=0x04 → interrupt_source=0x00 throughout; PENDING reads 0x04 after 2 cycles; ID reads 0; irq_any=0.
- ENABLE=0xFF, MODE=0x01, irq_in[0] pulsed high 1 cycle → interrupt_source=0x01 after 3 posedges and held. Write PENDING=0x01 → 0x00 next cycle. ID reads 0x8000_0000 while pending.
- MODE=0x00, ENABLE=0x30, irq_in=0x30 → interrupt_source=0x30 after 2 cycles; ID=0x8000_0004. Deassert irq_in[4] → ID=0x8000_0005 after 2 cycles. W1C of 0x30 has no effect.
- MODE=0x80, edge on irq_in[7] timed so the detect cycle coincides with a PENDING write of 0x80 → PENDING[7] remains 1.
- Pulse reset low mid-operation with PENDING=0xFF → interrupt_source=0, ENABLE=MODE=0 immediately (asynchronous). Lines held high afterward reappear only in level mode after 2 cycles.
- With IRQC_SW_TRIGGER_EN: ENABLE=0x02, write SWSET=0x02, irq_in=0 → interrupt_source=0x02 next cycle. W1C 0x02 → 0x00. Without the macro, the same write leaves interrupt_source=0x00.
